// File: rtl/eth_egress_pkt_arb_pkg.sv
// Shared types and helpers for the 2:1 packet-atomic egress arbiter.
package eth_egress_pkt_arb_pkg;
  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;
  typedef logic port_t;

  localparam int RUN_W = 8;

  // Weights of 0 behave as 1; large weights clamp to the run counter range.
  function automatic logic [RUN_W-1:0] sat_weight(input int w);
    if (w < 1) return RUN_W'(1);
    if (w >= 2**RUN_W) return '1;
    return RUN_W'(w);
  endfunction
endpackage

// File: rtl/eth_egress_pkt_arb_if.sv
// AXI-Stream beat bundle used for both arbiter inputs and the merged output.
interface eth_egress_pkt_arb_if #(parameter int DATA_W = 64);
  logic [DATA_W-1:0]   tdata;
  logic [DATA_W/8-1:0] tkeep;
  logic                tlast;
  logic                tvalid;
  logic                tready;

  modport master(output tdata, tkeep, tlast, tvalid, input tready);
  modport slave (input tdata, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/eth_egress_pkt_arb_axi_fifo_flop2.sv
// Two-entry flop FIFO used as the output skid stage; s_ready is purely registered.
module eth_egress_pkt_arb_axi_fifo_flop2 #(
  parameter int WIDTH = 73
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready
);
  logic [WIDTH-1:0] d0, d1;
  logic [1:0]       cnt;
  logic             push, pop;

  assign m_data  = d0;
  assign m_valid = (cnt != 2'd0);
  assign s_ready = (cnt != 2'd2);
  assign push    = s_valid & s_ready;
  assign pop     = m_valid & m_ready;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cnt <= 2'd0;
      d0  <= '0;
      d1  <= '0;
    end else begin
      case (cnt)
        2'd0: if (push) begin
          d0  <= s_data;
          cnt <= 2'd1;
        end
        2'd1: begin
          if (push && pop) d0 <= s_data;
          else if (push) begin
            d1  <= s_data;
            cnt <= 2'd2;
          end else if (pop) cnt <= 2'd0;
        end
        2'd2: if (pop) begin
          d0  <= d1;
          cnt <= 2'd1;
        end
        default: cnt <= 2'd0;
      endcase
    end
  end
endmodule

// File: rtl/eth_egress_pkt_arb.sv
// Packet-atomic weighted round-robin 2:1 AXI-Stream arbiter with pause and packet counters.
module eth_egress_pkt_arb
  import eth_egress_pkt_arb_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int WEIGHT0 = 4,
  parameter int WEIGHT1 = 1,
  parameter int CNT_W   = 32
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             pause_req,
  eth_egress_pkt_arb_if.slave  s0,
  eth_egress_pkt_arb_if.slave  s1,
  eth_egress_pkt_arb_if.master m,
  output logic [CNT_W-1:0] pkt_cnt0,
  output logic [CNT_W-1:0] pkt_cnt1,
  output logic             busy
);
  localparam int BEAT_W = DATA_W + DATA_W/8 + 1;
  localparam logic [RUN_W-1:0] W0 = sat_weight(WEIGHT0);
  localparam logic [RUN_W-1:0] W1 = sat_weight(WEIGHT1);

  state_t           state;
  port_t            last_port, pick;
  logic [RUN_W-1:0] run_cnt, cur_w;
  logic             any_req, eop;
  logic             st_valid, st_ready, out_valid;
  logic [BEAT_W-1:0] st_data, out_data;

  assign s0.tready = (state == GRANT0) & st_ready;
  assign s1.tready = (state == GRANT1) & st_ready;

  always_comb begin
    st_valid = 1'b0;
    st_data  = '0;
    case (state)
      GRANT0: begin
        st_valid = s0.tvalid;
        st_data  = {s0.tdata, s0.tkeep, s0.tlast};
      end
      GRANT1: begin
        st_valid = s1.tvalid;
        st_data  = {s1.tdata, s1.tkeep, s1.tlast};
      end
      default: ;
    endcase
  end

  assign eop     = st_valid & st_ready & st_data[0];
  assign any_req = s0.tvalid | s1.tvalid;
  assign cur_w   = last_port ? W1 : W0;

  // Stick with the last winner until it has used its weight, but only if the other side waits.
  always_comb begin
    pick = last_port;
    if (s0.tvalid && s1.tvalid) pick = (run_cnt < cur_w) ? last_port : ~last_port;
    else if (s0.tvalid)         pick = 1'b0;
    else if (s1.tvalid)         pick = 1'b1;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= IDLE;
      busy      <= 1'b0;
      last_port <= 1'b1;
      run_cnt   <= '0;
      pkt_cnt0  <= '0;
      pkt_cnt1  <= '0;
    end else begin
      case (state)
        IDLE: if (!pause_req && any_req) begin
          state     <= pick ? GRANT1 : GRANT0;
          busy      <= 1'b1;
          last_port <= pick;
          if (pick == last_port) run_cnt <= (run_cnt == '1) ? run_cnt : run_cnt + 1'b1;
          else                   run_cnt <= RUN_W'(1);
        end
        GRANT0: if (eop) begin
          state    <= IDLE;
          busy     <= 1'b0;
          pkt_cnt0 <= pkt_cnt0 + 1'b1;
        end
        GRANT1: if (eop) begin
          state    <= IDLE;
          busy     <= 1'b0;
          pkt_cnt1 <= pkt_cnt1 + 1'b1;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  eth_egress_pkt_arb_axi_fifo_flop2 #(.WIDTH(BEAT_W)) u_skid (
    .aclk    (aclk),
    .aresetn (aresetn),
    .s_data  (st_data),
    .s_valid (st_valid),
    .s_ready (st_ready),
    .m_data  (out_data),
    .m_valid (out_valid),
    .m_ready (m.tready)
  );

  assign {m.tdata, m.tkeep, m.tlast} = out_data;
  assign m.tvalid = out_valid;
endmodule
